// File: rtl/bsg_clk_mon_counter_pkg.sv
// Shared types and default widths for the clock-monitor frequency meter.
// The chip top and the readout logic import this so they agree on result widths.
`timescale 1ns/1ps
package bsg_clk_mon_counter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } bsg_clk_mon_state_e;

  localparam int clk_mon_window_lg_gp   = 12;
  localparam int clk_mon_count_width_gp = 16;

endpackage

// File: rtl/bsg_clk_mon_counter_if.sv
// Control and result handshake between the frequency meter and its consumer.
`timescale 1ns/1ps
interface bsg_clk_mon_counter_if
  import bsg_clk_mon_counter_pkg::*;
#(
  parameter int count_width_p = clk_mon_count_width_gp
) ();

  logic                     start_i;
  logic                     continuous_i;
  logic                     busy_o;
  logic                     v_o;
  logic                     ready_i;
  logic [count_width_p-1:0] count_o;
  logic                     overflow_o;

  modport master (
    input  start_i, continuous_i, ready_i,
    output busy_o, v_o, count_o, overflow_o
  );

  modport slave (
    output start_i, continuous_i, ready_i,
    input  busy_o, v_o, count_o, overflow_o
  );

endinterface

// File: rtl/bsg_clk_mon_sync_edge.sv
// Synchronizes an asynchronous clock-like signal into clk_i and flags each rising edge.
`timescale 1ns/1ps
module bsg_clk_mon_sync_edge #(
  parameter int sync_stages_p = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic edge_o
);

  logic [sync_stages_p-1:0] sync_q;
  logic                     prev_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[sync_stages_p-2:0], async_i};
      prev_q <= sync_q[sync_stages_p-1];
    end
  end

  assign edge_o = sync_q[sync_stages_p-1] & ~prev_q;

endmodule

// File: rtl/bsg_clk_mon_counter.sv
// Frequency meter: counts divided-monitor-clock edges over a fixed reference window
// and hands the saturating count to software over a valid/ready handshake.
`timescale 1ns/1ps
module bsg_clk_mon_counter
  import bsg_clk_mon_counter_pkg::*;
#(
  parameter int window_lg_p   = clk_mon_window_lg_gp,
  parameter int count_width_p = clk_mon_count_width_gp,
  parameter int sync_stages_p = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  div_clk_i,
  bsg_clk_mon_counter_if.master mon_if
);

  localparam int timer_width_lp = window_lg_p + 1;
  localparam logic [timer_width_lp-1:0] settle_last_lp = timer_width_lp'(sync_stages_p);
  localparam logic [timer_width_lp-1:0] window_last_lp = timer_width_lp'((1 << window_lg_p) - 1);

  bsg_clk_mon_state_e        state_r, state_n;
  logic [timer_width_lp-1:0] timer_r;
  logic [count_width_p-1:0]  cnt_r, cnt_n;
  logic                      ovf_r, ovf_n;
  logic [count_width_p-1:0]  result_cnt_r;
  logic                      result_ovf_r;
  logic                      div_edge;

  bsg_clk_mon_sync_edge #(
    .sync_stages_p(sync_stages_p)
  ) sync_edge (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .async_i(div_clk_i),
    .edge_o (div_edge)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= IDLE;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (mon_if.start_i) state_n = SETTLE;
      SETTLE:  if (timer_r == settle_last_lp) state_n = COUNT;
      COUNT:   if (timer_r == window_last_lp) state_n = DONE;
      DONE:    if (mon_if.ready_i) state_n = mon_if.continuous_i ? SETTLE : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // One timer serves both the settle delay and the window; it restarts on every state change.
  always_ff @(posedge clk_i) begin
    if (reset_i || (state_n != state_r))
      timer_r <= '0;
    else if ((state_r == SETTLE) || (state_r == COUNT))
      timer_r <= timer_r + timer_width_lp'(1);
  end

  always_comb begin
    cnt_n = cnt_r;
    ovf_n = ovf_r;
    if ((state_r == COUNT) && div_edge) begin
      if (&cnt_r) ovf_n = 1'b1;
      else        cnt_n = cnt_r + count_width_p'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || (state_r == SETTLE)) begin
      cnt_r <= '0;
      ovf_r <= 1'b0;
    end else begin
      cnt_r <= cnt_n;
      ovf_r <= ovf_n;
    end
  end

  // Capture the next-value so an edge in the final window cycle is included in the result.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      result_cnt_r <= '0;
      result_ovf_r <= 1'b0;
    end else if ((state_r == COUNT) && (state_n == DONE)) begin
      result_cnt_r <= cnt_n;
      result_ovf_r <= ovf_n;
    end
  end

  assign mon_if.busy_o     = (state_r != IDLE);
  assign mon_if.v_o        = (state_r == DONE);
  assign mon_if.count_o    = result_cnt_r;
  assign mon_if.overflow_o = result_ovf_r;

endmodule

// File: tb/tb_bsg_clk_mon_counter.sv
// Randomized self-checking bench for bsg_clk_mon_counter: a 16-bit and a 4-bit instance,
// both with a 256-cycle window, checked against edge counts derived from the div_clk period.
`timescale 1ns/1ps
module tb_bsg_clk_mon_counter;

  localparam int window_c  = 256;
  localparam int latency_c = 260;
  localparam int timeout_c = 2000;

  logic clk;
  logic reset;
  logic div_clk_a, div_clk_b;
  int   period_a, period_b;
  int   phase_a, phase_b;
  int   checks;
  int   fails;

  bsg_clk_mon_counter_if #(.count_width_p(16)) if_a ();
  bsg_clk_mon_counter_if #(.count_width_p(4))  if_b ();

  bsg_clk_mon_counter #(
    .window_lg_p(8), .count_width_p(16), .sync_stages_p(2)
  ) dut_a (
    .clk_i(clk), .reset_i(reset), .div_clk_i(div_clk_a), .mon_if(if_a)
  );

  bsg_clk_mon_counter #(
    .window_lg_p(8), .count_width_p(4), .sync_stages_p(2)
  ) dut_b (
    .clk_i(clk), .reset_i(reset), .div_clk_i(div_clk_b), .mon_if(if_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Divided clocks: a period below 2 means the monitor clock is stuck low.
  initial begin
    phase_a = 0;
    div_clk_a = 1'b0;
    forever begin
      @(negedge clk);
      if (period_a < 2) div_clk_a = 1'b0;
      else begin
        phase_a = (phase_a + 1 >= period_a) ? 0 : phase_a + 1;
        div_clk_a = (phase_a < period_a / 2);
      end
    end
  end

  initial begin
    phase_b = 0;
    div_clk_b = 1'b0;
    forever begin
      @(negedge clk);
      if (period_b < 2) div_clk_b = 1'b0;
      else begin
        phase_b = (phase_b + 1 >= period_b) ? 0 : phase_b + 1;
        div_clk_b = (phase_b < period_b / 2);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time expired, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts posedges from the one that samples start_i until v_o is seen.
  task automatic wait_result_a(output int n);
    n = 0;
    do begin
      @(posedge clk); n++; #1;
      if_a.start_i = 1'b0;
    end while (!if_a.v_o && n < timeout_c);
  endtask

  task automatic wait_result_b(output int n);
    n = 0;
    do begin
      @(posedge clk); n++; #1;
      if_b.start_i = 1'b0;
    end while (!if_b.v_o && n < timeout_c);
  endtask

  // Reference: a periodic clock yields floor or ceil of window/period edges in the window.
  function automatic bit count_ok(int cnt, int p);
    return (cnt * p >= window_c - p) && (cnt * p <= window_c + p);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    period_a = 6;
    period_b = 6;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      checks++;
      if (if_a.v_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_v: got %b, expected 0 (cycle %0d)", if_a.v_o, i); end
      checks++;
      if (if_a.busy_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b, expected 0 (cycle %0d)", if_a.busy_o, i); end
      checks++;
      if (if_a.count_o !== 16'd0 || if_a.overflow_o !== 1'b0)
        begin fails++; $display("[TB] FAIL reset_count: got %0d/%b, expected 0/0 (cycle %0d)", if_a.count_o, if_a.overflow_o, i); end
    end
    checks++;
    if (if_b.v_o !== 1'b0 || if_b.busy_o !== 1'b0 || if_b.count_o !== 4'd0)
      begin fails++; $display("[TB] FAIL reset_b: got v=%b busy=%b count=%0d, expected 0/0/0", if_b.v_o, if_b.busy_o, if_b.count_o); end
  endtask

  task automatic test_single();
    int n;
    int p;
    logic [15:0] saved;
    p = 8;
    period_a = p;
    if_a.continuous_i = 1'b0;
    if_a.ready_i = 1'b1;
    repeat (20) @(negedge clk);
    if_a.start_i = 1'b1;
    wait_result_a(n);
    checks++;
    if (n !== latency_c) begin fails++; $display("[TB] FAIL single_latency: got %0d cycles, expected %0d", n, latency_c); end
    checks++;
    if (!count_ok(int'(if_a.count_o), p)) begin fails++; $display("[TB] FAIL single_count: got %0d, expected %0d +/-1", if_a.count_o, window_c / p); end
    checks++;
    if (if_a.overflow_o !== 1'b0) begin fails++; $display("[TB] FAIL single_ovf: got %b, expected 0", if_a.overflow_o); end
    saved = if_a.count_o;
    @(posedge clk); #1;
    checks++;
    if (if_a.v_o !== 1'b0 || if_a.busy_o !== 1'b0)
      begin fails++; $display("[TB] FAIL single_after_hs: got v=%b busy=%b, expected 0/0", if_a.v_o, if_a.busy_o); end
    checks++;
    if (if_a.count_o !== saved) begin fails++; $display("[TB] FAIL single_hold: got %0d, expected %0d", if_a.count_o, saved); end
  endtask

  task automatic test_saturate();
    int n;
    if_b.continuous_i = 1'b0;
    if_b.ready_i = 1'b1;
    period_b = 4;
    repeat (20) @(negedge clk);
    if_b.start_i = 1'b1;
    wait_result_b(n);
    checks++;
    if (if_b.count_o !== 4'd15 || if_b.overflow_o !== 1'b1)
      begin fails++; $display("[TB] FAIL sat_count: got %0d/%b, expected 15/1", if_b.count_o, if_b.overflow_o); end
    period_b = 32;
    repeat (40) @(negedge clk);
    if_b.start_i = 1'b1;
    wait_result_b(n);
    checks++;
    if (!count_ok(int'(if_b.count_o), 32) || if_b.overflow_o !== 1'b0)
      begin fails++; $display("[TB] FAIL nosat_count: got %0d/%b, expected %0d +/-1 / 0", if_b.count_o, if_b.overflow_o, window_c / 32); end
  endtask

  task automatic test_continuous();
    int n;
    int p;
    int c0;
    int c;
    p = 10;
    period_a = p;
    if_a.continuous_i = 1'b1;
    if_a.ready_i = 1'b0;
    repeat (20) @(negedge clk);
    if_a.start_i = 1'b1;
    wait_result_a(n);
    checks++;
    if (n !== latency_c) begin fails++; $display("[TB] FAIL cont_latency0: got %0d, expected %0d", n, latency_c); end
    c0 = int'(if_a.count_o);
    checks++;
    if (!count_ok(c0, p)) begin fails++; $display("[TB] FAIL cont_count0: got %0d, expected %0d +/-1", c0, window_c / p); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (if_a.v_o !== 1'b1 || int'(if_a.count_o) != c0)
        begin fails++; $display("[TB] FAIL cont_stall: got v=%b count=%0d, expected 1/%0d", if_a.v_o, if_a.count_o, c0); end
    end
    for (int r = 1; r < 3; r++) begin
      @(negedge clk);
      if_a.ready_i = 1'b1;
      @(posedge clk); n = 1; #1;
      if_a.ready_i = 1'b0;
      checks++;
      if (if_a.v_o !== 1'b0 || if_a.busy_o !== 1'b1)
        begin fails++; $display("[TB] FAIL cont_rearm: got v=%b busy=%b, expected 0/1", if_a.v_o, if_a.busy_o); end
      while (!if_a.v_o && n < timeout_c) begin
        @(posedge clk); n++; #1;
      end
      checks++;
      if (n !== latency_c) begin fails++; $display("[TB] FAIL cont_latency: got %0d, expected %0d (run %0d)", n, latency_c, r); end
      c = int'(if_a.count_o);
      checks++;
      if (c < c0 - 1 || c > c0 + 1) begin fails++; $display("[TB] FAIL cont_repeat: got %0d, expected %0d +/-1 (run %0d)", c, c0, r); end
    end
    @(negedge clk);
    if_a.continuous_i = 1'b0;
    if_a.ready_i = 1'b1;
    @(posedge clk); #1;
    if_a.ready_i = 1'b0;
    checks++;
    if (if_a.v_o !== 1'b0 || if_a.busy_o !== 1'b0)
      begin fails++; $display("[TB] FAIL cont_stop: got v=%b busy=%b, expected 0/0", if_a.v_o, if_a.busy_o); end
  endtask

  task automatic test_stuck();
    int n;
    period_a = 0;
    if_a.ready_i = 1'b1;
    repeat (10) @(negedge clk);
    if_a.start_i = 1'b1;
    wait_result_a(n);
    checks++;
    if (n !== latency_c) begin fails++; $display("[TB] FAIL stuck_latency: got %0d, expected %0d", n, latency_c); end
    checks++;
    if (if_a.count_o !== 16'd0 || if_a.overflow_o !== 1'b0)
      begin fails++; $display("[TB] FAIL stuck_count: got %0d/%b, expected 0/0", if_a.count_o, if_a.overflow_o); end
  endtask

  task automatic test_start_ignored();
    int n;
    int p;
    p = 12;
    period_a = p;
    if_a.ready_i = 1'b1;
    repeat (30) @(negedge clk);
    if_a.start_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++; #1;
      if_a.start_i = (n == 100);
    end while (!if_a.v_o && n < timeout_c);
    checks++;
    if (n !== latency_c) begin fails++; $display("[TB] FAIL ignored_start_latency: got %0d, expected %0d", n, latency_c); end
    checks++;
    if (!count_ok(int'(if_a.count_o), p)) begin fails++; $display("[TB] FAIL ignored_start_count: got %0d, expected %0d +/-1", if_a.count_o, window_c / p); end
  endtask

  task automatic test_reset_mid();
    int n;
    bit bad;
    period_a = 5;
    if_a.ready_i = 1'b1;
    repeat (20) @(negedge clk);
    if_a.start_i = 1'b1;
    repeat (120) begin
      @(posedge clk); #1;
      if_a.start_i = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (if_a.v_o !== 1'b0 || if_a.busy_o !== 1'b0)
      begin fails++; $display("[TB] FAIL abort_state: got v=%b busy=%b, expected 0/0", if_a.v_o, if_a.busy_o); end
    checks++;
    if (if_a.count_o !== 16'd0 || if_a.overflow_o !== 1'b0)
      begin fails++; $display("[TB] FAIL abort_result: got %0d/%b, expected 0/0", if_a.count_o, if_a.overflow_o); end
    bad = 1'b0;
    repeat (300) begin
      @(posedge clk); #1;
      if (if_a.v_o !== 1'b0 || if_a.busy_o !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin fails++; $display("[TB] FAIL abort_quiet: got activity after reset, expected none"); end
    period_a = 16;
    repeat (40) @(negedge clk);
    if_a.start_i = 1'b1;
    wait_result_a(n);
    checks++;
    if (n !== latency_c) begin fails++; $display("[TB] FAIL restart_latency: got %0d, expected %0d", n, latency_c); end
    checks++;
    if (!count_ok(int'(if_a.count_o), 16)) begin fails++; $display("[TB] FAIL restart_count: got %0d, expected %0d +/-1", if_a.count_o, window_c / 16); end
  endtask

  task automatic test_back_to_back();
    int n;
    bit bad;
    period_a = 8;
    if_a.continuous_i = 1'b0;
    if_a.ready_i = 1'b0;
    repeat (20) @(negedge clk);
    if_a.start_i = 1'b1;
    wait_result_a(n);
    @(negedge clk);
    if_a.ready_i = 1'b1;
    if_a.start_i = 1'b1;
    @(posedge clk); #1;
    if_a.ready_i = 1'b0;
    if_a.start_i = 1'b0;
    checks++;
    if (if_a.v_o !== 1'b0 || if_a.busy_o !== 1'b0)
      begin fails++; $display("[TB] FAIL hs_start_drop: got v=%b busy=%b, expected 0/0", if_a.v_o, if_a.busy_o); end
    bad = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (if_a.busy_o !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin fails++; $display("[TB] FAIL hs_start_queued: got busy=1, expected 0"); end
    if_a.ready_i = 1'b1;
    if_a.start_i = 1'b1;
    wait_result_a(n);
    checks++;
    if (n !== latency_c || !count_ok(int'(if_a.count_o), 8))
      begin fails++; $display("[TB] FAIL b2b_run: got %0d cycles count %0d, expected %0d / %0d +/-1", n, if_a.count_o, latency_c, window_c / 8); end
  endtask

  task automatic test_random();
    int n;
    int p;
    if_a.ready_i = 1'b1;
    if_a.continuous_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      p = int'($urandom_range(2, 40));
      period_a = p;
      repeat (2 * p + 5) @(negedge clk);
      if_a.start_i = 1'b1;
      wait_result_a(n);
      checks++;
      if (n !== latency_c || !count_ok(int'(if_a.count_o), p) || if_a.overflow_o !== 1'b0)
        begin fails++; $display("[TB] FAIL random_run: period %0d got %0d cycles count %0d ovf %b, expected %0d / %0d +/-1 / 0", p, n, if_a.count_o, if_a.overflow_o, latency_c, window_c / p); end
    end
  endtask

  initial begin
    checks = 0;
    fails = 0;
    reset = 1'b1;
    period_a = 0;
    period_b = 0;
    if_a.start_i = 1'b0; if_a.continuous_i = 1'b0; if_a.ready_i = 1'b0;
    if_b.start_i = 1'b0; if_b.continuous_i = 1'b0; if_b.ready_i = 1'b0;
    test_reset();
    test_single();
    test_saturate();
    test_continuous();
    test_stuck();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
